// File: rtl/heading_pid_pkg.sv
// Shared widths, gains and helpers for the heading PID controller.
package heading_pid_pkg;
    localparam int HEAD_W  = 12;
    localparam int ERR_W   = 10;
    localparam int INTEG_W = 15;
    localparam int PID_W   = 14;
    localparam int DSAT_W  = 7;
    localparam int FRWRD_W = 10;
    localparam int SPD_W   = 11;

    localparam logic signed [5:0] P_COEFF = 6'sd6;
    localparam logic signed [5:0] D_COEFF = 6'sd19;

    // Two's-complement add overflow: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction
endpackage

// File: rtl/sat_signed.sv
// Combinational clamp of a signed value into a narrower signed range.
module sat_signed #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 10
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);
    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        dout = din[OUT_W-1:0];
        if (din > MAX_V)
            dout = MAX_V[OUT_W-1:0];
        else if (din < MIN_V)
            dout = MIN_V[OUT_W-1:0];
    end
endmodule

// File: rtl/heading_pid.sv
// Heading PID: registered error stage, PID stage, then differential motor speeds.
module heading_pid
    import heading_pid_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      moving,
    input  logic                      err_vld,
    input  logic signed [HEAD_W-1:0]  heading,
    input  logic signed [HEAD_W-1:0]  desired_heading,
    input  logic [FRWRD_W-1:0]        frwrd,
    output logic signed [SPD_W-1:0]   lft_spd,
    output logic signed [SPD_W-1:0]   rght_spd
);
    logic signed [HEAD_W-1:0]  raw_err;
    logic signed [ERR_W-1:0]   err_sat;
    logic signed [ERR_W-1:0]   err_reg;
    logic                      vld_reg;
    logic signed [ERR_W-1:0]   prev_err_reg;
    logic signed [INTEG_W-1:0] integ_reg;
    logic signed [PID_W-1:0]   pid_reg;
    logic signed [SPD_W-1:0]   lft_spd_reg;
    logic signed [SPD_W-1:0]   rght_spd_reg;

    // Modular subtraction makes the +/-180 degree wrap fall out naturally.
    assign raw_err = heading - desired_heading;

    sat_signed #(.IN_W(HEAD_W), .OUT_W(ERR_W)) u_err_sat (
        .din  (raw_err),
        .dout (err_sat)
    );

    logic signed [ERR_W:0]     err_diff;
    logic signed [DSAT_W-1:0]  d_sat;
    assign err_diff = {err_reg[ERR_W-1], err_reg} - {prev_err_reg[ERR_W-1], prev_err_reg};

    sat_signed #(.IN_W(ERR_W+1), .OUT_W(DSAT_W)) u_d_sat (
        .din  (err_diff),
        .dout (d_sat)
    );

    logic signed [PID_W-1:0]   p_term;
    logic signed [PID_W-1:0]   i_term;
    logic signed [PID_W-1:0]   d_term;
    logic signed [PID_W-1:0]   pid_sum;
    logic signed [INTEG_W-1:0] err_ext;
    logic signed [INTEG_W-1:0] integ_sum;
    logic                      integ_ovf;

    assign p_term  = {{(PID_W-ERR_W){err_reg[ERR_W-1]}}, err_reg}
                   * {{(PID_W-6){P_COEFF[5]}}, P_COEFF};
    assign d_term  = {{(PID_W-DSAT_W){d_sat[DSAT_W-1]}}, d_sat}
                   * {{(PID_W-6){D_COEFF[5]}}, D_COEFF};
    assign i_term  = {{(PID_W-9){integ_reg[INTEG_W-1]}}, integ_reg[INTEG_W-1:6]};
    assign pid_sum = p_term + i_term + d_term;

    assign err_ext   = {{(INTEG_W-ERR_W){err_reg[ERR_W-1]}}, err_reg};
    assign integ_sum = integ_reg + err_ext;
    assign integ_ovf = add_ovf(integ_reg[INTEG_W-1], err_ext[INTEG_W-1], integ_sum[INTEG_W-1]);

    logic [SPD_W-1:0] frwrd_ext;
    assign frwrd_ext = {1'b0, frwrd};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg      <= '0;
            vld_reg      <= 1'b0;
            prev_err_reg <= '0;
            integ_reg    <= '0;
            pid_reg      <= '0;
            lft_spd_reg  <= '0;
            rght_spd_reg <= '0;
        end else begin
            vld_reg <= err_vld;
            if (err_vld)
                err_reg <= err_sat;

            // The PID sum sees the integrator as it was before this edge.
            if (vld_reg) begin
                pid_reg      <= pid_sum;
                prev_err_reg <= err_reg;
            end

            if (!moving)
                integ_reg <= '0;
            else if (vld_reg && !integ_ovf)
                integ_reg <= integ_sum;

            if (!moving) begin
                lft_spd_reg  <= '0;
                rght_spd_reg <= '0;
            end else begin
                lft_spd_reg  <= frwrd_ext + pid_reg[PID_W-1:3];
                rght_spd_reg <= frwrd_ext - pid_reg[PID_W-1:3];
            end
        end
    end

    // Fractional PID bits are intentionally dropped at the speed stage.
    logic unused_pid_frac;
    assign unused_pid_frac = &{1'b0, pid_reg[2:0]};

    assign lft_spd  = lft_spd_reg;
    assign rght_spd = rght_spd_reg;
endmodule

// File: tb/tb_heading_pid.sv
// Self-checking bench for heading_pid: vector table, integer reference model, speed scoreboard.
module tb_heading_pid;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              moving = 1'b1;
    logic              err_vld = 1'b0;
    logic signed [11:0] heading = '0;
    logic signed [11:0] desired_heading = '0;
    logic [9:0]        frwrd = 10'h100;
    logic signed [10:0] lft_spd;
    logic signed [10:0] rght_spd;

    heading_pid dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .moving          (moving),
        .err_vld         (err_vld),
        .heading         (heading),
        .desired_heading (desired_heading),
        .frwrd           (frwrd),
        .lft_spd         (lft_spd),
        .rght_spd        (rght_spd)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int due;
        int lft;
        int rght;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [11:0] h;
        logic [11:0] d;
        logic [9:0]  f;
        int          exp_err;
    } vec_t;
    vec_t vecs[10];

    int m_integ = 0;
    int m_prev  = 0;
    int m_pid   = 0;

    function automatic int wrapw(input int v, input int w);
        int r;
        r = v & ((1 << w) - 1);
        if (r >= (1 << (w - 1))) r = r - (1 << w);
        return r;
    endfunction

    function automatic int satw(input int v, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Speed scoreboard: every transaction's speeds must appear at exactly its due edge.
    always @(negedge clk) begin
        if (rst_n && sb.size() > 0 && sb[0].due <= edge_cnt) begin
            sb_t e;
            e = sb.pop_front();
            if (e.due != edge_cnt)
                chk("sb_latency", edge_cnt, e.due);
            else begin
                chk("sb_lft", int'(lft_spd), e.lft);
                chk("sb_rght", int'(rght_spd), e.rght);
            end
            $display("txn due=%0d lft=%0d rght=%0d exp_lft=%0d exp_rght=%0d",
                     e.due, lft_spd, rght_spd, e.lft, e.rght);
        end
    end

    // Drive one err_vld sample at a negedge and push the model's expected speeds.
    task automatic push_vld(input logic [11:0] h, input logic [11:0] d, input logic [9:0] f);
        int e;
        int dd;
        int s;
        sb_t ent;
        heading         = h;
        desired_heading = d;
        frwrd           = f;
        err_vld         = 1'b1;
        e  = satw(wrapw(int'(h) - int'(d), 12), 10);
        dd = satw(e - m_prev, 7);
        m_pid = wrapw(e * 6 + (m_integ >>> 6) + dd * 19, 14);
        if (moving) begin
            s = m_integ + e;
            if (s <= 16383 && s >= -16384) m_integ = s;
        end
        m_prev   = e;
        ent.due  = edge_cnt + 3;
        ent.lft  = wrapw(int'(f) + (m_pid >>> 3), 11);
        ent.rght = wrapw(int'(f) - (m_pid >>> 3), 11);
        sb.push_back(ent);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            chk("sb_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        err_vld = 1'b0;
        sb.delete();
        m_integ = 0;
        m_prev  = 0;
        m_pid   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{12'h7F0, 12'h810, 10'h080, -32};
        vecs[1] = '{12'h400, 12'h000, 10'h100, 511};
        vecs[2] = '{12'hC00, 12'h000, 10'h050, -512};
        vecs[3] = '{12'h000, 12'h7FF, 10'h200, -512};
        vecs[4] = '{12'h800, 12'h001, 10'h3FF, 511};
        vecs[5] = '{12'h123, 12'h100, 10'h0F0, 35};
        vecs[6] = '{12'h0FF, 12'h100, 10'h000, -1};
        vecs[7] = '{12'h1FF, 12'h000, 10'h010, 511};
        vecs[8] = '{12'hE00, 12'h000, 10'h010, -512};
        vecs[9] = '{12'h000, 12'h000, 10'h1A0, 0};

        // Reset state with arbitrary inputs
        heading = 12'h3A5; desired_heading = 12'h0F1; err_vld = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_lft", int'(lft_spd), 0);
        chk("rst_rght", int'(rght_spd), 0);
        chk("rst_pid", int'(dut.pid_reg), 0);
        chk("rst_integ", int'(dut.integ_reg), 0);
        err_vld = 1'b0; heading = '0; desired_heading = '0;
        rst_n = 1'b1;
        @(negedge clk);

        // Zero error: speeds equal frwrd
        push_vld(12'h000, 12'h000, 10'h100);
        @(negedge clk);
        err_vld = 1'b0;
        wait_idle();
        chk("zero_err_lft", int'(lft_spd), 256);
        chk("zero_err_rght", int'(rght_spd), 256);

        // Worked example with exact latency
        push_vld(12'h100, 12'h000, 10'h100);
        @(negedge clk);
        err_vld = 1'b0;
        chk("ex_err", int'(dut.err_reg), 256);
        @(negedge clk);
        chk("ex_lft_early", int'(lft_spd), 256);
        chk("ex_pid", int'(dut.pid_reg), 2733);
        @(negedge clk);
        chk("ex_lft", int'(lft_spd), 597);
        chk("ex_rght", int'(rght_spd), -85);
        chk("ex_integ", int'(dut.integ_reg), 256);

        // Vector table: error wrap/saturation, speeds via scoreboard
        for (int i = 0; i < 10; i++) begin
            push_vld(vecs[i].h, vecs[i].d, vecs[i].f);
            @(negedge clk);
            err_vld = 1'b0;
            chk($sformatf("vec%0d_err", i), int'(dut.err_reg), vecs[i].exp_err);
            wait_idle();
        end
        chk("table_integ", int'(dut.integ_reg), m_integ);

        // frwrd change alone reaches outputs in one edge
        frwrd = 10'h155;
        @(negedge clk);
        chk("frwrd_lft", int'(lft_spd), wrapw(341 + (m_pid >>> 3), 11));
        chk("frwrd_rght", int'(rght_spd), wrapw(341 - (m_pid >>> 3), 11));

        // Integrator saturation with back-to-back strobes
        do_reset();
        for (int i = 0; i < 32; i++) begin
            push_vld(12'h400, 12'h000, 10'h100);
            @(negedge clk);
        end
        err_vld = 1'b0;
        wait_idle();
        chk("integ_32", int'(dut.integ_reg), 16352);
        push_vld(12'h400, 12'h000, 10'h100);
        @(negedge clk);
        err_vld = 1'b0;
        wait_idle();
        chk("integ_33_hold", int'(dut.integ_reg), 16352);
        chk("integ_model", int'(dut.integ_reg), m_integ);

        // One-cycle moving drop clears speeds and integrator
        moving = 1'b0;
        @(negedge clk);
        chk("stop_lft", int'(lft_spd), 0);
        chk("stop_rght", int'(rght_spd), 0);
        chk("stop_integ", int'(dut.integ_reg), 0);
        m_integ = 0;
        moving = 1'b1;
        @(negedge clk);
        chk("resume_lft", int'(lft_spd), wrapw(256 + (m_pid >>> 3), 11));
        push_vld(12'h400, 12'h000, 10'h100);
        @(negedge clk);
        err_vld = 1'b0;
        wait_idle();
        chk("restart_integ", int'(dut.integ_reg), 511);

        // Reset mid-flight discards the in-flight sample
        push_vld(12'h300, 12'h000, 10'h050);
        @(negedge clk);
        err_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        m_integ = 0; m_prev = 0; m_pid = 0;
        #1;
        chk("midrst_lft", int'(lft_spd), 0);
        chk("midrst_pid", int'(dut.pid_reg), 0);
        chk("midrst_vld", int'(dut.vld_reg), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_vld(12'h100, 12'h000, 10'h100);
        @(negedge clk);
        err_vld = 1'b0;
        wait_idle();
        chk("postrst_lft", int'(lft_spd), 597);
        chk("postrst_rght", int'(rght_spd), -85);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
